// File: rtl/mem_arbiter_if.sv
// Requester-side bundle of the wram arbiter: request/grant handshake, access
// attributes and read return for both masters.
interface mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          req0;
  logic          wr0;
  logic          lock0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          gnt0;
  logic          rvalid0;
  logic [DW-1:0] rdata0;

  logic          req1;
  logic          wr1;
  logic          lock1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          gnt1;
  logic          rvalid1;
  logic [DW-1:0] rdata1;

  modport master (
    output req0, wr0, lock0, addr0, wdata0,
    output req1, wr1, lock1, addr1, wdata1,
    input  gnt0, rvalid0, rdata0,
    input  gnt1, rvalid1, rdata1
  );

  modport slave (
    input  req0, wr0, lock0, addr0, wdata0,
    input  req1, wr1, lock1, addr1, wdata1,
    output gnt0, rvalid0, rdata0,
    output gnt1, rvalid1, rdata1
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master arbiter for the single-port wram: round-robin with bounded lock.
// Define MEM_ARB_FIXED_PRIO_EN to make master 0 always win contention in IDLE.
module mem_arbiter #(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int MAX_LOCK = 8
) (
  input  logic          Clock,
  input  logic          Reset,
  mem_arbiter_if.slave  bus,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  output logic          mem_wren,
  input  logic [DW-1:0] mem_q
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOCKED0 = 2'd1,
    LOCKED1 = 2'd2
  } state_t;

  localparam logic [7:0] MAX_LOCK_C = 8'(MAX_LOCK);

  state_t        state, state_nxt;
  logic [7:0]    lock_cnt, lock_cnt_nxt;
  logic          idle_seen, idle_seen_nxt;
  logic          last_owner;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;
  logic          rvalid0_q, rvalid1_q;
  logic          g0, g1;
  logic          own_req, own_lock;
  logic [7:0]    lock_cnt_inc;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      lock_cnt   <= '0;
      idle_seen  <= 1'b0;
      last_owner <= 1'b1;
      addr_q     <= '0;
      data_q     <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      state     <= state_nxt;
      lock_cnt  <= lock_cnt_nxt;
      idle_seen <= idle_seen_nxt;
      rvalid0_q <= g0 & ~bus.wr0;
      rvalid1_q <= g1 & ~bus.wr1;
      if (g0 || g1) begin
        last_owner <= g1;
        addr_q     <= mem_addr;
        data_q     <= mem_data;
      end
    end
  end

  assign own_req      = (state == LOCKED1) ? bus.req1  : bus.req0;
  assign own_lock     = (state == LOCKED1) ? bus.lock1 : bus.lock0;
  assign lock_cnt_inc = lock_cnt + 8'd1;

  always_comb begin
    state_nxt     = state;
    lock_cnt_nxt  = lock_cnt;
    idle_seen_nxt = idle_seen;
    unique case (state)
      IDLE: begin
        lock_cnt_nxt  = '0;
        idle_seen_nxt = 1'b0;
        // A limit of one means the entry grant already exhausts the lock.
        if (MAX_LOCK_C > 8'd1) begin
          if (g0 && bus.lock0) begin
            state_nxt    = LOCKED0;
            lock_cnt_nxt = 8'd1;
          end else if (g1 && bus.lock1) begin
            state_nxt    = LOCKED1;
            lock_cnt_nxt = 8'd1;
          end
        end
      end
      LOCKED0, LOCKED1: begin
        lock_cnt_nxt  = lock_cnt_inc;
        idle_seen_nxt = ~own_req;
        if ((own_req && !own_lock) || (!own_req && idle_seen) ||
            (lock_cnt_inc >= MAX_LOCK_C)) begin
          state_nxt     = IDLE;
          lock_cnt_nxt  = '0;
          idle_seen_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt     = IDLE;
        lock_cnt_nxt  = '0;
        idle_seen_nxt = 1'b0;
      end
    endcase
  end

  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req0 && bus.req1) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
          g0 = 1'b1;
`else
          g0 = last_owner;
          g1 = ~last_owner;
`endif
        end else begin
          g0 = bus.req0;
          g1 = bus.req1;
        end
      end
      LOCKED0: g0 = bus.req0;
      LOCKED1: g1 = bus.req1;
      default: begin
        g0 = 1'b0;
        g1 = 1'b0;
      end
    endcase
    if (Reset) begin
      g0 = 1'b0;
      g1 = 1'b0;
    end

    mem_addr = addr_q;
    mem_data = data_q;
    mem_wren = 1'b0;
    if (g0) begin
      mem_addr = bus.addr0;
      mem_data = bus.wdata0;
      mem_wren = bus.wr0;
    end else if (g1) begin
      mem_addr = bus.addr1;
      mem_data = bus.wdata1;
      mem_wren = bus.wr1;
    end
  end

  assign bus.gnt0    = g0;
  assign bus.gnt1    = g1;
  assign bus.rvalid0 = rvalid0_q;
  assign bus.rvalid1 = rvalid1_q;
  assign bus.rdata0  = mem_q;
  assign bus.rdata1  = mem_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter that shares the single-port synchronous wram (16-bit address, 16-bit data, 1-cycle read latency) between the processor load/store port (master 0) and a secondary requester (master 1, e.g. display scan or DMA).
- Grants at most one access per cycle, round-robin by default, with an optional bounded lock for back-to-back accesses.
- Sits between proc/chipselect and wram. Drives the RAM address, data and wren, and routes q back to the owning master.

Parameters:
- AW, 16, address width
- DW, 16, data width
- MAX_LOCK, 8, maximum consecutive cycles a locked master may hold ownership (range 1..255)

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- req0  in  1  master 0 access request; held high until gnt0
- wr0  in  1  master 0 write (1) / read (0)
- lock0  in  1  master 0 requests to keep ownership after this access
- addr0  in  AW  master 0 address
- wdata0  in  DW  master 0 write data
- gnt0  out  1  master 0 access accepted this cycle
- rvalid0  out  1  master 0 read data valid
- rdata0  out  DW  master 0 read data
- req1, wr1, lock1, addr1, wdata1, gnt1, rvalid1, rdata1: same roles for master 1
- mem_addr  out  AW  RAM address
- mem_data  out  DW  RAM write data
- mem_wren  out  1  RAM write enable
- mem_q  in  DW  RAM read data, valid one cycle after its address

Behaviour:
- Reset values: gnt0=gnt1=0, rvalid0=rvalid1=0, mem_wren=0, mem_addr=0, mem_data=0. State=IDLE, last_owner=1 (so master 0 wins the first contention), lock_cnt=0.
- States:
  - IDLE: no lock held.
  - LOCKED0 / LOCKED1: the named master owns the RAM exclusively.
- Grant decision in IDLE (combinational, same cycle as req):
  - Only one req high: grant that master.
  - Both high: grant the master that is not last_owner.
  - Neither high: no grant, mem_wren=0, mem_addr holds its previous value.
- Granted cycle:
  - gnt for the winning master is 1 for exactly that cycle.
  - mem_addr=addrN and mem_data=wdataN are driven combinationally from the winner.
  - mem_wren=wrN.
  - last_owner<=N on the next edge.
- Read return:
  - If the granted access is a read, rvalidN=1 on the cycle after the grant, and rdataN=mem_q during that cycle.
  - Writes never raise rvalid.
  - rdataN is don't-care when rvalidN=0; the implementation drives mem_q to both rdata ports.
- Throughput: one access per cycle. A grant may coexist with the previous access's rvalid. Back-to-back reads from alternating masters produce alternating rvalids.
- Lock entry: a grant to N with lockN=1 moves IDLE->LOCKEDN and loads lock_cnt=1.
- While in LOCKEDN:
  - Only reqN can be granted; the other master is stalled, gnt=0.
  - Each grant to N increments lock_cnt.
  - Cycles where N is not requesting also increment lock_cnt, so the hold is bounded in cycles.
- Lock exit: return to IDLE when any of the following holds:
  - lockN is sampled 0 on a granted access.
  - lock_cnt reaches MAX_LOCK; the access at the limit is still granted.
  - reqN is low for 2 consecutive cycles.
- Fairness after lock release: last_owner=N, so the other master wins the next contention.
- Asynchronous Reset mid-operation: all state and outputs return to reset values immediately. A pending rvalid is dropped, and the requester must re-request.
- Address and data width: no arithmetic on address or data; values pass through unmodified.

Optional Feature:
- Macro MEM_ARB_FIXED_PRIO_EN.
- Defined: master 0 always wins contention in IDLE, last_owner is ignored for the decision, and the lock mechanism is unchanged.
- Undefined: round-robin as specified above.

Test Plan:
- Reset then single read: req0=1, wr0=0, addr0=0x0005 with RAM[5]=0xBEEF -> gnt0=1 in cycle t, mem_addr=0x0005, mem_wren=0; rvalid0=1 and rdata0=0xBEEF in t+1.
- Contention: req0 and req1 held high for 4 cycles with no locks -> grant order 0,1,0,1. With MEM_ARB_FIXED_PRIO_EN the order is 0,0,0,0.
- Write then read: master 1 writes 0x1234 to 0x0010, then master 0 reads 0x0010 -> mem_wren=1 only in the write grant cycle; rvalid0 returns 0x1234; rvalid1 never asserts.
- Lock bound: MAX_LOCK=4, lock0=1, req0 and req1 held continuously -> exactly 4 consecutive gnt0, then gnt1 on the 5th cycle.
- Lock release by idle: master 0 locks, then drops req0 for 2 cycles while req1=1 -> gnt1 asserts in the cycle after the second idle cycle.
- Async reset mid-read: assert Reset between a read grant and its return -> rvalid0=0 immediately and all outputs at reset values; after deassertion the first contended grant goes to master 0.
